// File: rtl/latch_bank_lockout_pkg.sv
// Shared types for the latch bank: FSM state encoding and the group-enable expansion helper.
package latch_bank_pkg;

   typedef enum logic [1:0] {
      OPEN   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int MAX_CHANNELS = 64;

   // Channel i belongs to group i / (channels / groups).
   function automatic logic [MAX_CHANNELS-1:0] expand_en(
      input logic [MAX_CHANNELS-1:0] en,
      input int                      channels,
      input int                      groups
   );
      int per;
      per = channels / groups;
      expand_en = '0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         if (i < channels) expand_en[i] = en[i / per];
      end
   endfunction

endpackage

// File: rtl/latch_bank_lockout_if.sv
// Channel data/enable/control bundle for the latch bank; q_n exists only with LATCH_BANK_COMPLEMENT_EN.
interface latch_bank_lockout_if #(
   parameter int CHANNELS = 4,
   parameter int GROUPS   = 2,
   parameter int IDXW     = $clog2(CHANNELS)
);
   logic [CHANNELS-1:0] d;
   logic [GROUPS-1:0]   en;
   logic                arm;
   logic                clear;
   logic [CHANNELS-1:0] q;
`ifdef LATCH_BANK_COMPLEMENT_EN
   logic [CHANNELS-1:0] q_n;
`endif
   logic                locked;
   logic                armed;
   logic [IDXW-1:0]     winner;
   logic                tie;

   modport master (
      output d, en, arm, clear,
      input  q, locked, armed, winner, tie
`ifdef LATCH_BANK_COMPLEMENT_EN
      , input q_n
`endif
   );

   modport slave (
      input  d, en, arm, clear,
      output q, locked, armed, winner, tie
`ifdef LATCH_BANK_COMPLEMENT_EN
      , output q_n
`endif
   );
endinterface

// File: rtl/latch_bank_lockout_lowest_set_encoder.sv
// Lowest-set-bit encoder: index of the lowest set bit, plus any-set and multi-hot flags.
module lowest_set_encoder #(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDXW-1:0]  idx,
   output logic             any,
   output logic             multi
);

   // Scan from the top down so the last assignment is the lowest set bit.
   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDXW'(i);
      end
   end

   assign any   = |vec;
   assign multi = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/latch_bank_lockout.sv
// Clocked latch bank with per-group enables and first-press lockout.
// Build option LATCH_BANK_COMPLEMENT_EN adds a registered complement output q_n.
//
// state  | meaning
// OPEN   | groups follow d while their enable is high
// ARMED  | groups follow d; first enabled high channel locks the bank
// LOCKED | q, winner, tie frozen until clear
module latch_bank_lockout
   import latch_bank_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int GROUPS   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   latch_bank_lockout_if.slave  bus
);

   localparam int IDXW = $clog2(CHANNELS);

   state_t              state, state_nxt;
   logic [CHANNELS-1:0] q_r, q_nxt;
   logic [IDXW-1:0]     winner_r, winner_nxt;
   logic                tie_r, tie_nxt;

   logic [MAX_CHANNELS-1:0] en_wide;
   logic [CHANNELS-1:0]     mask, hit, follow;
   logic [IDXW-1:0]         hit_idx;
   logic                    hit_any, hit_multi;

   assign en_wide = MAX_CHANNELS'(bus.en);
   assign mask    = CHANNELS'(expand_en(en_wide, CHANNELS, GROUPS));
   assign hit     = bus.d & mask;
   assign follow  = (q_r & ~mask) | hit;

   lowest_set_encoder #(.WIDTH(CHANNELS), .IDXW(IDXW)) u_enc (
      .vec   (hit),
      .idx   (hit_idx),
      .any   (hit_any),
      .multi (hit_multi)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= OPEN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.clear && bus.arm) begin
         state_nxt = ARMED;
      end else if (bus.clear) begin
         state_nxt = OPEN;
      end else begin
         case (state)
            OPEN:    if (bus.arm) state_nxt = ARMED;
            ARMED:   if (hit_any) state_nxt = LOCKED;
            LOCKED:  state_nxt = LOCKED;
            default: state_nxt = OPEN;
         endcase
      end
   end

   // clear alone in OPEN has nothing to release, so the bank keeps following.
   always_comb begin
      q_nxt      = q_r;
      winner_nxt = winner_r;
      tie_nxt    = tie_r;
      if (bus.clear && bus.arm) begin
         q_nxt      = '0;
         winner_nxt = '0;
         tie_nxt    = 1'b0;
      end else if (bus.clear) begin
         if (state == OPEN) q_nxt = follow;
         winner_nxt = '0;
         tie_nxt    = 1'b0;
      end else begin
         case (state)
            OPEN: begin
               q_nxt      = bus.arm ? '0 : follow;
               winner_nxt = '0;
               tie_nxt    = 1'b0;
            end
            ARMED: begin
               if (hit_any) begin
                  q_nxt      = hit;
                  winner_nxt = hit_idx;
                  tie_nxt    = hit_multi;
               end else begin
                  q_nxt = follow;
               end
            end
            LOCKED: ;
            default: begin
               q_nxt      = '0;
               winner_nxt = '0;
               tie_nxt    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r      <= '0;
         winner_r <= '0;
         tie_r    <= 1'b0;
      end else begin
         q_r      <= q_nxt;
         winner_r <= winner_nxt;
         tie_r    <= tie_nxt;
      end
   end

`ifdef LATCH_BANK_COMPLEMENT_EN
   logic [CHANNELS-1:0] q_n_r;
   always_ff @(posedge clk) begin
      if (rst) q_n_r <= '1;
      else     q_n_r <= ~q_nxt;
   end
   assign bus.q_n = q_n_r;
`endif

   assign bus.q      = q_r;
   assign bus.winner = winner_r;
   assign bus.tie    = tie_r;
   assign bus.locked = (state == LOCKED);
   assign bus.armed  = (state == ARMED);

endmodule

// File: tb/tb_latch_bank_lockout.sv
// Scoreboard bench for latch_bank_lockout: directed vectors push expected outputs, a monitor checks them.
module tb_latch_bank_lockout;

   typedef struct packed {
      logic [3:0] q;
      logic       locked;
      logic       armed;
      logic [1:0] winner;
      logic       tie;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   latch_bank_lockout_if #(.CHANNELS(4), .GROUPS(2)) bus ();

   latch_bank_lockout #(.CHANNELS(4), .GROUPS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t exp_q[$];
   int   vec_id_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   next_id = 0;

   task automatic step(input logic r, input logic [3:0] d, input logic [1:0] en,
                       input logic arm, input logic clr,
                       input logic [3:0] eq, input logic elk, input logic earm,
                       input logic [1:0] ewin, input logic etie);
      exp_t e;
      @(negedge clk);
      rst       = r;
      bus.d     = d;
      bus.en    = en;
      bus.arm   = arm;
      bus.clear = clr;
      e.q = eq; e.locked = elk; e.armed = earm; e.winner = ewin; e.tie = etie;
      exp_q.push_back(e);
      vec_id_q.push_back(next_id);
      next_id++;
   endtask

   // Monitor: every edge that has a pending expectation is checked 1 ns after it.
   always @(posedge clk) begin
      exp_t e;
      int   id;
      #1;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         id = vec_id_q.pop_front();
         vectors++;
         if (bus.q !== e.q || bus.locked !== e.locked || bus.armed !== e.armed ||
             bus.winner !== e.winner || bus.tie !== e.tie) begin
            miscompares++;
            $display("FAIL vec%0d q/locked/armed/winner/tie got %b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b",
                     id, bus.q, bus.locked, bus.armed, bus.winner, bus.tie,
                     e.q, e.locked, e.armed, e.winner, e.tie);
         end
`ifdef LATCH_BANK_COMPLEMENT_EN
         if (bus.q_n !== ~e.q) begin
            miscompares++;
            $display("FAIL vec%0d q_n got %b want %b", id, bus.q_n, ~e.q);
         end
`endif
      end
   end

   initial begin
      bus.d = 4'b0000; bus.en = 2'b00; bus.arm = 1'b0; bus.clear = 1'b0;

      //    rst  d        en     arm  clr   q        lk   arm  win    tie
      step(1'b1, 4'b1111, 2'b11, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // reset state
      step(1'b0, 4'b1111, 2'b01, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0); // group 0 follows
      step(1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0); // group 1 loads 0
      step(1'b0, 4'b1100, 2'b10, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1'b0, 4'b1111, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0); // arm clears q
      step(1'b0, 4'b0100, 2'b11, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0); // single winner
      step(1'b0, 4'b1111, 2'b11, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0); // frozen
      step(1'b0, 4'b0001, 2'b11, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0); // arm ignored in LOCKED
      step(1'b1, 4'b0001, 2'b11, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // reset mid-lock
      step(1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
      step(1'b0, 4'b1010, 2'b11, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 2'd1, 1'b1); // tie
      step(1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0); // clear+arm re-arms
      step(1'b0, 4'b0001, 2'b10, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0); // masked group
      step(1'b0, 4'b1000, 2'b10, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd3, 1'b0);
      step(1'b0, 4'b0000, 2'b11, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0); // clear from LOCKED
      step(1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
      step(1'b0, 4'b0001, 2'b11, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // clear beats capture
      step(1'b0, 4'b0010, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0); // d not loaded on arm
      step(1'b0, 4'b0010, 2'b11, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0); // held press locks
      step(1'b0, 4'b0000, 2'b11, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
      step(1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0); // re-arm no effect
      step(1'b0, 4'b0001, 2'b01, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);

      @(negedge clk);
      bus.arm = 1'b0; bus.clear = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
